// File: rtl/unified_cache_ctrl.sv
// Unified direct-mapped write-back cache controller for the core's I and D ports.
// Data port has priority; misses run writeback and refill as word beats toward memory.
module unified_cache_ctrl #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned INDEX_W        = 6,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rd,
    output logic [DATA_W-1:0] i_rd_data,
    output logic              i_miss,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    input  logic              d_rd,
    input  logic              d_wr,
    output logic [DATA_W-1:0] d_rd_data,
    output logic              d_miss,
    input  logic              flush,
    output logic              flush_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    localparam int unsigned OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFF_W - 2;
    localparam int unsigned LINES   = 1 << INDEX_W;
    localparam int unsigned WORDS   = LINES * WORDS_PER_LINE;
    localparam int unsigned WADDR_W = INDEX_W + OFF_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, FLUSH} state_t;

    logic [DATA_W-1:0]  data_q [WORDS];
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [LINES-1:0]   valid_q, dirty_q;
    state_t             state_q, state_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic [INDEX_W-1:0] line_q, line_d;
    logic [TAG_W-1:0]   mtag_q, mtag_d;
    logic [INDEX_W-1:0] midx_q, midx_d;

    // Address fields of both ports
    logic [TAG_W-1:0]   d_tag, i_tag, t_tag;
    logic [INDEX_W-1:0] d_idx, i_idx, t_idx;
    logic [OFF_W-1:0]   d_off, i_off;
    logic               d_req, d_hit, i_hit, served, want_fill, last_beat;
    logic               unused_addr_bits;

    assign d_tag = d_addr[ADDR_W-1 -: TAG_W];
    assign d_idx = d_addr[2+OFF_W +: INDEX_W];
    assign d_off = d_addr[2 +: OFF_W];
    assign i_tag = i_addr[ADDR_W-1 -: TAG_W];
    assign i_idx = i_addr[2+OFF_W +: INDEX_W];
    assign i_off = i_addr[2 +: OFF_W];
    assign unused_addr_bits = ^{d_addr[1:0], i_addr[1:0]};

    assign d_req     = d_rd | d_wr;
    assign d_hit     = valid_q[d_idx] && (tag_q[d_idx] == d_tag);
    assign i_hit     = valid_q[i_idx] && (tag_q[i_idx] == i_tag);
    assign served    = d_req ? d_hit : (i_rd && i_hit);
    assign want_fill = d_req ? !d_hit : (i_rd && !i_hit);
    assign t_tag     = d_req ? d_tag : i_tag;
    assign t_idx     = d_req ? d_idx : i_idx;
    assign last_beat = (beat_q == OFF_W'(WORDS_PER_LINE - 1));
    assign flush_busy = (state_q == FLUSH);

    // Array update strobes, one line index per cycle
    logic               wr_en, tag_we, set_valid, clr_valid, set_dirty, clr_dirty, line_done;
    logic [WADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic [INDEX_W-1:0] upd_idx;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        line_d    = line_q;
        mtag_d    = mtag_q;
        midx_d    = midx_q;
        i_miss    = i_rd;
        d_miss    = d_req;
        i_rd_data = '0;
        d_rd_data = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        tag_we    = 1'b0;
        set_valid = 1'b0;
        clr_valid = 1'b0;
        set_dirty = 1'b0;
        clr_dirty = 1'b0;
        line_done = 1'b0;
        upd_idx   = '0;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    d_miss = !d_hit;
                    if (d_hit && d_rd) d_rd_data = data_q[{d_idx, d_off}];
                    if (d_hit && d_wr) begin
                        wr_en     = 1'b1;
                        wr_addr   = {d_idx, d_off};
                        wr_data   = d_wr_data;
                        set_dirty = 1'b1;
                        upd_idx   = d_idx;
                    end
                end else if (i_rd) begin
                    i_miss = !i_hit;
                    if (i_hit) i_rd_data = data_q[{i_idx, i_off}];
                end
                if (flush && !served) begin
                    state_d = FLUSH;
                    line_d  = '0;
                    beat_d  = '0;
                end else if (want_fill) begin
                    mtag_d = t_tag;
                    midx_d = t_idx;
                    beat_d = '0;
                    if (valid_q[t_idx] && dirty_q[t_idx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d   = REFILL;
                        clr_valid = 1'b1;
                        upd_idx   = t_idx;
                    end
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[midx_q], midx_q, beat_q, 2'b00};
                mem_wdata = data_q[{midx_q, beat_q}];
                if (mem_ack) begin
                    beat_d = beat_q + OFF_W'(1);
                    if (last_beat) begin
                        state_d   = REFILL;
                        clr_dirty = 1'b1;
                        clr_valid = 1'b1;
                        upd_idx   = midx_q;
                    end
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {mtag_q, midx_q, beat_q, 2'b00};
                if (mem_ack) begin
                    wr_en   = 1'b1;
                    wr_addr = {midx_q, beat_q};
                    wr_data = mem_rdata;
                    beat_d  = beat_q + OFF_W'(1);
                    if (last_beat) begin
                        tag_we    = 1'b1;
                        set_valid = 1'b1;
                        clr_dirty = 1'b1;
                        upd_idx   = midx_q;
                        state_d   = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (valid_q[line_q] && dirty_q[line_q]) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {tag_q[line_q], line_q, beat_q, 2'b00};
                    mem_wdata = data_q[{line_q, beat_q}];
                    if (mem_ack) begin
                        beat_d    = beat_q + OFF_W'(1);
                        line_done = last_beat;
                    end
                end else begin
                    line_done = 1'b1;
                end
                if (line_done) begin
                    clr_valid = 1'b1;
                    clr_dirty = 1'b1;
                    upd_idx   = line_q;
                    if (line_q == INDEX_W'(LINES - 1)) state_d = IDLE;
                    else line_d = line_q + INDEX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, valid and dirty bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            line_q  <= '0;
            mtag_q  <= '0;
            midx_q  <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            mtag_q  <= mtag_d;
            midx_q  <= midx_d;
            if (set_valid)      valid_q[upd_idx] <= 1'b1;
            else if (clr_valid) valid_q[upd_idx] <= 1'b0;
            if (set_dirty)      dirty_q[upd_idx] <= 1'b1;
            else if (clr_dirty) dirty_q[upd_idx] <= 1'b0;
        end
    end

    // Data and tag arrays are not reset; valid bits guard them
    always_ff @(posedge clk) begin
        if (wr_en)  data_q[wr_addr] <= wr_data;
        if (tag_we) tag_q[midx_q]   <= mtag_q;
    end
endmodule

// File: tb/tb_unified_cache_ctrl.sv
// Directed bench for unified_cache_ctrl with a memory that acks every 2nd cycle and returns the address as data.
module tb_unified_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr, d_addr, d_wr_data, i_rd_data, d_rd_data;
    logic        i_rd, i_miss, d_rd, d_wr, d_miss, flush, flush_busy;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        model_ack, force_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int n_beats  = 0;
    int base;
    logic [31:0] log_addr  [128];
    logic [31:0] log_wdata [128];
    logic        log_we    [128];

    unified_cache_ctrl #(.ADDR_W(32), .DATA_W(32), .INDEX_W(4), .WORDS_PER_LINE(4)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_rd(i_rd), .i_rd_data(i_rd_data), .i_miss(i_miss),
        .d_addr(d_addr), .d_wr_data(d_wr_data), .d_rd(d_rd), .d_wr(d_wr),
        .d_rd_data(d_rd_data), .d_miss(d_miss),
        .flush(flush), .flush_busy(flush_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    assign mem_ack = model_ack | force_ack;

    // Memory model and beat log
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_ack <= 1'b0;
            mem_rdata <= '0;
        end else begin
            model_ack <= mem_req && !model_ack;
            mem_rdata <= mem_addr;
            if (mem_req && mem_ack && n_beats < 128) begin
                log_addr[n_beats]  <= mem_addr;
                log_wdata[n_beats] <= mem_wdata;
                log_we[n_beats]    <= mem_we;
                n_beats            <= n_beats + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_d_served(input string tag);
        int n = 0;
        while (d_miss && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_timeout"}, 32'(d_miss), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_addr = '0; i_rd = 1'b0; d_addr = '0; d_wr_data = '0;
        d_rd = 1'b0; d_wr = 1'b0; flush = 1'b0; force_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_flush_busy", 32'(flush_busy), 32'd0);
        check("rst_d_rd_data", d_rd_data, 32'd0);

        // 1: cold read miss and refill
        @(negedge clk);
        base = n_beats; d_rd = 1'b1; d_addr = 32'h104;
        #1;
        check("t1_miss", 32'(d_miss), 32'd1);
        wait_d_served("t1");
        check("t1_data", d_rd_data, 32'h104);
        check("t1_beats", 32'(n_beats - base), 32'd4);
        check("t1_addr0", log_addr[base], 32'h100);
        check("t1_addr3", log_addr[base+3], 32'h10C);
        check("t1_we", 32'(log_we[base]), 32'd0);

        // 2: write hit, then conflicting read forces writeback
        @(negedge clk);
        d_rd = 1'b0; d_wr = 1'b1; d_addr = 32'h104; d_wr_data = 32'hDEADBEEF;
        #1;
        check("t2_wr_hit", 32'(d_miss), 32'd0);
        @(negedge clk);
        base = n_beats; d_wr = 1'b0; d_rd = 1'b1; d_addr = 32'h504;
        #1;
        check("t2_miss", 32'(d_miss), 32'd1);
        wait_d_served("t2");
        check("t2_beats", 32'(n_beats - base), 32'd8);
        check("t2_wb_addr0", log_addr[base], 32'h100);
        check("t2_wb_we", 32'(log_we[base]), 32'd1);
        check("t2_wb_data1", log_wdata[base+1], 32'hDEADBEEF);
        check("t2_wb_addr3", log_addr[base+3], 32'h10C);
        check("t2_rf_addr0", log_addr[base+4], 32'h500);
        check("t2_rf_we", 32'(log_we[base+4]), 32'd0);
        check("t2_data", d_rd_data, 32'h504);

        // 3: simultaneous hits, data port first
        @(negedge clk);
        d_addr = 32'h504; i_rd = 1'b1; i_addr = 32'h508;
        #1;
        check("t3_d_miss", 32'(d_miss), 32'd0);
        check("t3_d_data", d_rd_data, 32'h504);
        check("t3_i_forced", 32'(i_miss), 32'd1);
        @(negedge clk);
        d_rd = 1'b0;
        #1;
        check("t3_i_miss", 32'(i_miss), 32'd0);
        check("t3_i_data", i_rd_data, 32'h508);

        // 4: dirty lines 0 and 15, then flush
        @(negedge clk);
        i_rd = 1'b0; d_wr = 1'b1; d_addr = 32'h504; d_wr_data = 32'hCAFE0000;
        #1;
        check("t4_wr0", 32'(d_miss), 32'd0);
        @(negedge clk);
        d_addr = 32'h0F4; d_wr_data = 32'h12345678;
        #1;
        wait_d_served("t4_wr15");
        @(negedge clk);
        d_wr = 1'b0; flush = 1'b1; base = n_beats;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("t4_busy", 32'(flush_busy), 32'd1);
        for (int n = 0; n < 300 && flush_busy; n++) begin
            @(negedge clk); #1;
        end
        check("t4_busy_end", 32'(flush_busy), 32'd0);
        check("t4_beats", 32'(n_beats - base), 32'd8);
        check("t4_addr0", log_addr[base], 32'h500);
        check("t4_wdata1", log_wdata[base+1], 32'hCAFE0000);
        check("t4_addr4", log_addr[base+4], 32'h0F0);
        check("t4_wdata5", log_wdata[base+5], 32'h12345678);
        check("t4_addr7", log_addr[base+7], 32'h0FC);
        check("t4_we7", 32'(log_we[base+7]), 32'd1);
        @(negedge clk);
        d_rd = 1'b1; d_addr = 32'h504;
        #1;
        check("t4_post_miss0", 32'(d_miss), 32'd1);
        wait_d_served("t4_refetch");
        check("t4_refetch_data", d_rd_data, 32'h504);

        // 5: reset in the middle of a refill
        @(negedge clk);
        d_addr = 32'h0F4; base = n_beats;
        #1;
        check("t5_miss15", 32'(d_miss), 32'd1);
        for (int n = 0; n < 100 && n_beats < base + 2; n++) @(negedge clk);
        #1;
        check("t5_req_before", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_req_rst", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0; base = n_beats;
        #1;
        check("t5_miss_again", 32'(d_miss), 32'd1);
        wait_d_served("t5");
        check("t5_beats", 32'(n_beats - base), 32'd4);
        check("t5_addr0", log_addr[base], 32'h0F0);
        check("t5_addr3", log_addr[base+3], 32'h0FC);
        check("t5_data", d_rd_data, 32'h0F4);

        // 6: stray acks in IDLE change nothing
        @(negedge clk);
        d_rd = 1'b0; force_ack = 1'b1; base = n_beats;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk); #1;
            check("t6_req", 32'(mem_req), 32'd0);
        end
        force_ack = 1'b0;
        d_rd = 1'b1; d_addr = 32'h0F4;
        #1;
        check("t6_hit", 32'(d_miss), 32'd0);
        check("t6_data", d_rd_data, 32'h0F4);
        check("t6_no_beats", 32'(n_beats - base), 32'd0);
        check("t6_busy", 32'(flush_busy), 32'd0);
        @(negedge clk);
        d_rd = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
